// File: rtl/hall_meas_pkg.sv
// Shared encodings and defaults for the Hall/encoder frequency meter.
package hall_meas_pkg;

    // Edge qualification selected by the edge_mode input.
    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_RSVD = 2'b11
    } edge_mode_e;

    // One second gate at a 100 MHz system clock.
    localparam int unsigned GATE_CYCLES_DEFAULT = 32'd100_000_000;

    // Qualify an edge from the synchronised level and its one-cycle-delayed copy.
    // The reserved encoding falls back to rising-edge detection.
    function automatic logic qualify_edge(
        input logic [1:0] mode,
        input logic       cur,
        input logic       prev
    );
        logic hit;
        case (edge_mode_e'(mode))
            EDGE_FALL: hit = ~cur & prev;
            EDGE_BOTH: hit = cur ^ prev;
            default:   hit = cur & ~prev;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One measurement channel: input synchroniser, edge qualifier,
// saturating working counter and sticky saturation flag.
module edge_chan
    import hall_meas_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             count_en,
    input  logic             clear,
    input  logic [1:0]       edge_mode,
    input  logic             signal,
    output logic [CNT_W-1:0] cnt_next,
    output logic             ovf_next
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   edge_hit;
    logic [CNT_W-1:0]       work_q;
    logic                   ovf_q;
    logic                   at_max;

    // Synchroniser chain plus edge-delay flop; free-running so that
    // re-enabling never sees a stale level as a new edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], signal};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign at_max = &work_q;

    // Edge qualification and saturating next-count. The next value is exported
    // so the gate's terminal-cycle edge lands in the published count even though
    // the working register is cleared on that same cycle.
    always_comb begin
        edge_hit = count_en & qualify_edge(edge_mode, sync_q[SYNC_STAGES-1], dly_q);
        cnt_next = work_q;
        if (edge_hit && !at_max) begin
            cnt_next = work_q + 1'b1;
        end
        ovf_next = ovf_q | (edge_hit & at_max);
    end

    // Working count and sticky saturation flag, restarted on every gate boundary
    // and held at zero while the meter is disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            work_q <= '0;
            ovf_q  <= 1'b0;
        end else if (clear) begin
            work_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            work_q <= cnt_next;
            ovf_q  <= ovf_next;
        end
    end

endmodule

// File: rtl/hall_freq_meter.sv
// Multi-channel Hall/encoder edge counter over a fixed gate period.
// A shared gate timer publishes every channel's count at each gate end.
module hall_freq_meter
    import hall_meas_pkg::*;
#(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [1:0]              edge_mode,
    input  logic [NUM_CH-1:0]       signal,
    output logic [NUM_CH*CNT_W-1:0] count_out,
    output logic                    count_valid,
    output logic [NUM_CH-1:0]       overflow
);

    localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    logic [GATE_W-1:0]       gate_cnt;
    logic                    gate_last;
    logic                    chan_clear;
    logic [NUM_CH*CNT_W-1:0] cnt_next;
    logic [NUM_CH-1:0]       ovf_next;

    assign gate_last  = enable && (gate_cnt == GATE_LAST);
    assign chan_clear = !enable || gate_last;

    // Gate timer: counts 0..GATE_CYCLES-1 while enabled, parked at 0 otherwise,
    // so the first enabled cycle is always cycle 0 of a full gate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gate_cnt <= '0;
        end else if (chan_clear) begin
            gate_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        edge_chan #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .count_en  (enable),
            .clear     (chan_clear),
            .edge_mode (edge_mode),
            .signal    (signal[i]),
            .cnt_next  (cnt_next[i*CNT_W +: CNT_W]),
            .ovf_next  (ovf_next[i])
        );
    end

    // Output latch: capture all channels on the terminal gate cycle and
    // flag the update one cycle later; outputs hold while disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_out   <= '0;
            overflow    <= '0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= gate_last;
            if (gate_last) begin
                count_out <= cnt_next;
                overflow  <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_hall_freq_meter.sv
// Directed bench for hall_freq_meter: an 8-bit and a 4-bit instance share
// the same stimulus; expected values are hand-computed per gate.
module tb_hall_freq_meter;

    localparam int unsigned GATE = 100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [1:0]  edge_mode;
    logic [2:0]  signal;

    logic [23:0] count8;
    logic        cv8;
    logic [2:0]  ovf8;
    logic [11:0] count4;
    logic        cv4;
    logic [2:0]  ovf4;

    logic        wave_on  = 1'b0;
    logic        wave_sig = 1'b0;
    int unsigned wave_ph  = 0;
    logic        tog_on   = 1'b0;
    logic        tog_sig  = 1'b0;
    logic        man_sig  = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    always #5 clk = ~clk;

    assign signal = {1'b0, (tog_on ? tog_sig : 1'b0), (wave_on ? wave_sig : man_sig)};

    hall_freq_meter #(
        .NUM_CH      (3),
        .CNT_W       (8),
        .GATE_CYCLES (GATE),
        .SYNC_STAGES (2)
    ) dut8 (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .edge_mode   (edge_mode),
        .signal      (signal),
        .count_out   (count8),
        .count_valid (cv8),
        .overflow    (ovf8)
    );

    hall_freq_meter #(
        .NUM_CH      (3),
        .CNT_W       (4),
        .GATE_CYCLES (GATE),
        .SYNC_STAGES (2)
    ) dut4 (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .edge_mode   (edge_mode),
        .signal      (signal),
        .count_out   (count4),
        .count_valid (cv4),
        .overflow    (ovf4)
    );

    // Square wave on ch0, period 10 cycles.
    always @(negedge clk) begin
        if (wave_on) begin
            if (wave_ph == 4) begin
                wave_ph  = 0;
                wave_sig = ~wave_sig;
            end else begin
                wave_ph++;
            end
        end
    end

    // ch1 toggles every cycle.
    always @(negedge clk) begin
        if (tog_on) tog_sig = ~tog_sig;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Wait (on negedges) for the next count_valid; returns cycles waited.
    task automatic wait_valid(output int unsigned n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cv8 && n < 400);
        if (!cv8) check("valid_timeout", 64'(cv8), 64'd1);
        check("valid_agree", 64'(cv4), 64'(cv8));
    endtask

    function automatic logic [7:0] c8(input int i);
        return count8[i*8 +: 8];
    endfunction

    function automatic logic [3:0] c4(input int i);
        return count4[i*4 +: 4];
    endfunction

    initial begin
        int unsigned n;
        int unsigned nv;

        reset_n   = 1'b0;
        enable    = 1'b1;
        edge_mode = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_count8", 64'(count8), 64'd0);
        check("rst_count4", 64'(count4), 64'd0);
        check("rst_valid", 64'(cv8), 64'd0);
        check("rst_ovf", 64'({ovf8, ovf4}), 64'd0);

        // First gate starts on the first cycle out of reset.
        reset_n = 1'b1;
        wait_valid(n);
        check("first_latency", 64'(n), 64'(GATE));
        check("quiet_gate", 64'(count8), 64'd0);

        // Rising edges of a period-10 square wave.
        wave_on = 1'b1;
        wait_valid(n);
        wait_valid(n);
        check("rise_period", 64'(n), 64'(GATE));
        check("rise_ch0", 64'(c8(0)), 64'd10);
        check("rise_ch1", 64'(c8(1)), 64'd0);
        check("rise_ch2", 64'(c8(2)), 64'd0);
        check("rise_ovf", 64'(ovf8), 64'd0);
        check("rise_ch0_w4", 64'(c4(0)), 64'd10);
        wait_valid(n);
        check("rise_period2", 64'(n), 64'(GATE));
        check("rise_ch0_2", 64'(c8(0)), 64'd10);

        // Both edges: 20, which saturates the 4-bit instance.
        edge_mode = 2'b10;
        wait_valid(n);
        wait_valid(n);
        check("both_ch0", 64'(c8(0)), 64'd20);
        check("both_ch0_w4", 64'(c4(0)), 64'd15);
        check("both_ovf_w4", 64'(ovf4), 64'd1);

        edge_mode = 2'b01;
        wait_valid(n);
        wait_valid(n);
        check("fall_ch0", 64'(c8(0)), 64'd10);
        check("fall_ovf_w4", 64'(ovf4), 64'd0);

        edge_mode = 2'b11;
        wait_valid(n);
        wait_valid(n);
        check("rsvd_ch0", 64'(c8(0)), 64'd10);

        // ch1 toggling every cycle in both-edge mode saturates CNT_W=4.
        edge_mode = 2'b10;
        wave_on   = 1'b0;
        tog_on    = 1'b1;
        wait_valid(n);
        wait_valid(n);
        check("sat_ch1_w4", 64'(c4(1)), 64'd15);
        check("sat_ovf_w4", 64'(ovf4), 64'b010);
        check("sat_ch1_w8", 64'(c8(1)), 64'd100);
        check("sat_ovf_w8", 64'(ovf8), 64'd0);
        check("sat_ch0_w8", 64'(c8(0)), 64'd0);
        tog_on = 1'b0;
        wait_valid(n);
        wait_valid(n);
        check("unsat_ch1_w4", 64'(c4(1)), 64'd0);
        check("unsat_ovf_w4", 64'(ovf4), 64'd0);

        // Drop enable at gate cycle 50, re-raise 30 cycles later.
        edge_mode = 2'b00;
        wave_on   = 1'b1;
        wait_valid(n);
        wait_valid(n);
        check("pre_dis_ch0", 64'(c8(0)), 64'd10);
        repeat (50) @(negedge clk);
        enable = 1'b0;
        nv = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (cv8) nv++;
        end
        check("dis_no_valid", 64'(nv), 64'd0);
        check("dis_hold_ch0", 64'(c8(0)), 64'd10);
        enable = 1'b1;
        wait_valid(n);
        check("reen_latency", 64'(n), 64'(GATE));
        check("reen_ch0", 64'(c8(0)), 64'd10);

        // Asynchronous reset mid-gate, asserted away from any clock edge.
        repeat (40) @(negedge clk);
        check("pre_rst_ch0", 64'(c8(0)), 64'd10);
        wave_on = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_count", 64'(count8), 64'd0);
        check("async_rst_valid", 64'(cv8), 64'd0);
        check("async_rst_ovf", 64'(ovf8), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_valid(n);
        check("rel_latency", 64'(n), 64'(GATE));
        check("rel_count", 64'(count8), 64'd0);

        // Edge on the terminal gate cycle, then one on the first cycle of the next.
        edge_mode = 2'b10;
        repeat (97) @(negedge clk);
        man_sig = 1'b1;
        @(negedge clk);
        man_sig = 1'b0;
        wait_valid(n);
        check("term_wait", 64'(n), 64'd2);
        check("term_edge_ch0", 64'(c8(0)), 64'd1);
        wait_valid(n);
        check("first_edge_ch0", 64'(c8(0)), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
